// File: rtl/ram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_slot_arbiter
// Purpose  : Shared system RAM time-slice scheduler. Generates the 6809 E/Q
//            clocks and gives each E half-period to one RAM owner: video
//            fetches while E is low, CPU accesses while E is high, and a
//            write-only loader port in any slot its owner leaves unused.
// Options  : RAM_ARB_LDR_EN - when defined, the loader port is present.
//            When undefined, ldr_* inputs are ignored and ldr_ack stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module ram_slot_arbiter #(
    parameter int HALF = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        e,
    output logic        q,
    input  logic [14:0] cpu_addr,
    input  logic        cpu_ram_cs,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic [14:0] vdg_addr,
    input  logic        vdg_req,
    output logic        vdg_ack,
    output logic [7:0]  vdg_data,
    input  logic [14:0] ldr_addr,
    input  logic [7:0]  ldr_data,
    input  logic        ldr_req,
    output logic        ldr_ack,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    input  logic [7:0]  ram_dout
);
    localparam int CW = $clog2(2 * HALF);

    localparam logic [CW-1:0] CNT_LAST    = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] CNT_HALF    = CW'(HALF);
    localparam logic [CW-1:0] CNT_Q_RISE  = CW'(HALF / 2);
    localparam logic [CW-1:0] CNT_Q_FALL  = CW'(3 * HALF / 2);
    localparam logic [CW-1:0] CNT_WR_DATA = CW'(2 * HALF - 3);
    localparam logic [CW-1:0] OFS_1       = CW'(1);
    localparam logic [CW-1:0] OFS_2       = CW'(2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VID    = 3'd1;
    localparam logic [2:0] S_CPU_RD = 3'd2;
    localparam logic [2:0] S_CPU_WR = 3'd3;
    localparam logic [2:0] S_LDR    = 3'd4;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] ofs;
    logic          slot_start;
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          ldr_go;

    logic [14:0]   addr_nxt;
    logic [7:0]    din_nxt;
    logic          we_nxt;
    logic          vack_nxt;
    logic          lack_nxt;
    logic          vdg_cap;
    logic          cpu_cap;

    assign cnt_nxt    = (cnt == CNT_LAST) ? '0 : cnt + OFS_1;
    // Position inside the current slot; both slots start at offset 0.
    assign ofs        = (cnt >= CNT_HALF) ? cnt - CNT_HALF : cnt;
    assign slot_start = (cnt == '0) || (cnt == CNT_HALF);

`ifdef RAM_ARB_LDR_EN
    assign ldr_go = ldr_req;
`else
    // Loader port is absent: its inputs are deliberately left dangling.
    logic unused_ldr;
    assign unused_ldr = ^{ldr_addr, ldr_data, ldr_req};
    assign ldr_go     = 1'b0;
`endif

    // State register: the slot owner, replaced only at slot boundaries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: pick the owner of the slot starting this cycle.
    always_comb begin
        state_nxt = state;
        if (slot_start) begin
            if (cnt == '0) begin
                if (vdg_req)     state_nxt = S_VID;
                else if (ldr_go) state_nxt = S_LDR;
                else             state_nxt = S_IDLE;
            end else begin
                if (cpu_ram_cs)  state_nxt = cpu_rw ? S_CPU_RD : S_CPU_WR;
                else if (ldr_go) state_nxt = S_LDR;
                else             state_nxt = S_IDLE;
            end
        end
    end

    // Output decode: next values of the registered RAM/ack outputs.
    always_comb begin
        addr_nxt = ram_addr;
        din_nxt  = ram_din;
        we_nxt   = 1'b0;
        vack_nxt = 1'b0;
        lack_nxt = 1'b0;
        vdg_cap  = 1'b0;
        cpu_cap  = 1'b0;

        // Address (and loader data) are latched as the new slot begins.
        if (slot_start) begin
            case (state_nxt)
                S_VID:              addr_nxt = vdg_addr;
                S_CPU_RD, S_CPU_WR: addr_nxt = cpu_addr;
`ifdef RAM_ARB_LDR_EN
                S_LDR: begin
                    addr_nxt = ldr_addr;
                    din_nxt  = ldr_data;
                    we_nxt   = 1'b1;
                end
`endif
                default: ;
            endcase
        end

        // ram_dout is valid two cycles after the slot start.
        case (state)
            S_VID: begin
                vdg_cap  = (ofs == OFS_2);
                vack_nxt = (ofs == OFS_2);
            end
            S_CPU_RD: cpu_cap = (ofs == OFS_2);
            S_CPU_WR: begin
                // CPU write data settles late in E high; sample it last.
                if (cnt == CNT_WR_DATA) begin
                    din_nxt = cpu_dout;
                    we_nxt  = 1'b1;
                end
            end
`ifdef RAM_ARB_LDR_EN
            S_LDR: lack_nxt = (ofs == OFS_1);
`endif
            default: ;
        endcase
    end

    // Datapath: slot counter, E/Q clocks, RAM port and read-data holding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            e        <= 1'b0;
            q        <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            vdg_ack  <= 1'b0;
            ldr_ack  <= 1'b0;
            vdg_data <= '0;
            cpu_din  <= '0;
        end else begin
            cnt      <= cnt_nxt;
            e        <= (cnt_nxt >= CNT_HALF);
            q        <= (cnt_nxt >= CNT_Q_RISE) && (cnt_nxt < CNT_Q_FALL);
            ram_addr <= addr_nxt;
            ram_din  <= din_nxt;
            ram_we   <= we_nxt;
            vdg_ack  <= vack_nxt;
            ldr_ack  <= lack_nxt;
            if (vdg_cap) vdg_data <= ram_dout;
            if (cpu_cap) cpu_din  <= ram_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_slot_arbiter
// Purpose  : Self-checking bench for ram_slot_arbiter. A slot-level model
//            predicts every registered output each cycle; directed phases
//            cover the E/Q waveform, video fetch, CPU write/read, loader
//            arbitration and mid-slot reset, then a randomized phase follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_slot_arbiter;
    localparam int HALF = 32;
    localparam int PER  = 2 * HALF;
`ifdef RAM_ARB_LDR_EN
    localparam bit LDR_EN = 1'b1;
`else
    localparam bit LDR_EN = 1'b0;
`endif
    localparam int O_IDLE = 0, O_VID = 1, O_RD = 2, O_WR = 3, O_LDR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        e, q;
    logic [14:0] cpu_addr, vdg_addr, ldr_addr, ram_addr;
    logic        cpu_ram_cs, cpu_rw, vdg_req, ldr_req;
    logic [7:0]  cpu_dout, cpu_din, vdg_data, ldr_data, ram_din, ram_dout;
    logic        vdg_ack, ldr_ack, ram_we;

    logic [7:0]  mem     [0:32767];
    logic [7:0]  ref_mem [0:32767];

    int checks = 0;
    int errors = 0;

    // Model state: current cnt, global cycle index, and per-slot schedule.
    int mc, g, owner;
    int s_addr;
    int we_at, vack_at, lack_at, vdat_at, cdin_at, wsamp_at;
    logic        exp_e, exp_q, exp_we, exp_vack, exp_lack;
    logic [14:0] exp_addr;
    logic [7:0]  exp_din, exp_vdata, exp_cdin;
    bit          rand_mode = 1'b0;

    ram_slot_arbiter #(.HALF(HALF)) dut (
        .clk(clk), .reset(reset), .e(e), .q(q),
        .cpu_addr(cpu_addr), .cpu_ram_cs(cpu_ram_cs), .cpu_rw(cpu_rw),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .vdg_addr(vdg_addr), .vdg_req(vdg_req), .vdg_ack(vdg_ack),
        .vdg_data(vdg_data),
        .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_req(ldr_req),
        .ldr_ack(ldr_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read RAM.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cnt %0d)", tag, got, exp, mc);
        end
    endtask

    task automatic model_reset();
        mc = 0; owner = O_IDLE;
        we_at = -1; vack_at = -1; lack_at = -1; vdat_at = -1; cdin_at = -1; wsamp_at = -1;
        exp_e = 0; exp_q = 0; exp_we = 0; exp_vack = 0; exp_lack = 0;
        exp_addr = '0; exp_din = '0; exp_vdata = '0; exp_cdin = '0;
    endtask

    // Predict the outputs of the next cycle from the inputs now on the pins.
    task automatic model_edge();
        if (!reset) begin
            model_reset();
            g++;
            return;
        end
        if (mc % HALF == 0) begin
            if (mc == 0)
                owner = vdg_req ? O_VID : (LDR_EN && ldr_req) ? O_LDR : O_IDLE;
            else
                owner = cpu_ram_cs ? (cpu_rw ? O_RD : O_WR) : (LDR_EN && ldr_req) ? O_LDR : O_IDLE;
            case (owner)
                O_VID: begin s_addr = int'(vdg_addr); vack_at = g + 3; vdat_at = g + 3; end
                O_RD:  begin s_addr = int'(cpu_addr); cdin_at = g + 3; end
                O_WR:  begin s_addr = int'(cpu_addr); wsamp_at = g + HALF - 3; we_at = g + HALF - 2; end
                O_LDR: begin
                    s_addr = int'(ldr_addr); exp_din = ldr_data;
                    we_at = g + 1; lack_at = g + 2;
                end
                default: ;
            endcase
            if (owner != O_IDLE) exp_addr = 15'(s_addr);
        end
        if (g == wsamp_at) exp_din = cpu_dout;
        g++;
        mc = (mc + 1) % PER;
        exp_we   = (g == we_at);
        exp_vack = (g == vack_at);
        exp_lack = (g == lack_at);
        if (g == vdat_at) exp_vdata = ref_mem[s_addr];
        if (g == cdin_at) exp_cdin  = ref_mem[s_addr];
        exp_e = (mc >= HALF);
        exp_q = (mc >= HALF / 2) && (mc < 3 * HALF / 2);
    endtask

    task automatic check_outputs();
        check("e", e, exp_e);
        check("q", q, exp_q);
        check("ram_we", ram_we, exp_we);
        check("ram_addr", ram_addr, exp_addr);
        check("ram_din", ram_din, exp_din);
        check("vdg_ack", vdg_ack, exp_vack);
        check("ldr_ack", ldr_ack, exp_lack);
        check("vdg_data", vdg_data, exp_vdata);
        check("cpu_din", cpu_din, exp_cdin);
        if (exp_we) ref_mem[exp_addr] = exp_din;
    endtask

    task automatic randomize_inputs();
        if ($urandom_range(0, 7) == 0) begin
            vdg_req  = $urandom_range(0, 1);
            vdg_addr = 15'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 7) == 0) begin
            cpu_ram_cs = $urandom_range(0, 1);
            cpu_rw     = $urandom_range(0, 1);
            cpu_addr   = 15'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 3) == 0) cpu_dout = 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            ldr_req  = $urandom_range(0, 1);
            ldr_addr = 15'($urandom_range(0, 15));
            ldr_data = 8'($urandom);
        end
        reset = ($urandom_range(0, 599) != 0);
    endtask

    // One clock: model the coming edge, then check after it.
    task automatic tick();
        if (rand_mode) randomize_inputs();
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 3 * PER; i++) begin
            if (mc == target) return;
            tick();
        end
        check("wait_cnt_timeout", mc, target);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 8'(i) ^ 8'(i >> 8);
            ref_mem[i] = 8'(i) ^ 8'(i >> 8);
        end
        mem[15'h0400] = 8'hA5; ref_mem[15'h0400] = 8'hA5;

        reset = 1'b0;
        cpu_addr = '0; cpu_ram_cs = 0; cpu_rw = 1; cpu_dout = '0;
        vdg_addr = '0; vdg_req = 0; ldr_addr = '0; ldr_data = '0; ldr_req = 0;
        g = 0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        repeat (3) tick();

        // Free running after reset release: E/Q waveform, no writes.
        reset = 1'b1;
        tick();
        wait_cnt(16); check("q_rise", q, 1'b1);
        wait_cnt(32); check("e_rise", e, 1'b1);
        wait_cnt(48); check("q_fall", q, 1'b0);
        repeat (70) tick();

        // Video fetch held for several E periods.
        vdg_req = 1'b1; vdg_addr = 15'h0400;
        wait_cnt(3);
        check("vdg_ack_cnt3", vdg_ack, 1'b1);
        check("vdg_data_a5", vdg_data, 8'hA5);
        repeat (2 * PER) tick();
        vdg_req = 1'b0;

        // CPU write then read back.
        wait_cnt(15);
        cpu_ram_cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 15'h1234; cpu_dout = 8'h3C;
        wait_cnt(62);
        check("wr_we", ram_we, 1'b1);
        check("wr_addr", ram_addr, 15'h1234);
        check("wr_din", ram_din, 8'h3C);
        cpu_rw = 1'b1;
        wait_cnt(35);
        check("rd_back", cpu_din, 8'h3C);
        cpu_ram_cs = 1'b0;

        // Video and loader both requesting, CPU idle.
        wait_cnt(40);
        vdg_req = 1'b1; ldr_req = 1'b1; ldr_addr = 15'h0055; ldr_data = 8'h99;
        wait_cnt(3);
        check("vid_keeps_slot", vdg_ack, 1'b1);
        wait_cnt(33);
`ifdef RAM_ARB_LDR_EN
        check("ldr_we", ram_we, 1'b1);
        check("ldr_addr", ram_addr, 15'h0055);
`endif
        wait_cnt(34);
`ifdef RAM_ARB_LDR_EN
        check("ldr_ack", ldr_ack, 1'b1);
        ldr_req = 1'b0;
`endif
        wait_cnt(3);
        check("vid_keeps_slot2", vdg_ack, 1'b1);

        // Reset in the middle of a loader slot.
        ldr_req = 1'b1; ldr_addr = 15'h0066; ldr_data = 8'h77;
        wait_cnt(33);
        reset = 1'b0; ldr_req = 1'b0; vdg_req = 1'b0;
        repeat (3) tick();
        check("rst_no_ack", ldr_ack, 1'b0);
        check("rst_no_we", ram_we, 1'b0);
        check("rst_addr", ram_addr, 15'h0);
        reset = 1'b1;
        tick();
        check("rst_e", e, 1'b0);

`ifndef RAM_ARB_LDR_EN
        // Loader held with the port absent.
        ldr_req = 1'b1; ldr_addr = 15'h0077; ldr_data = 8'hEE;
        repeat (4 * PER) tick();
        check("noldr_mem", mem[15'h0077], 8'h77 ^ 8'h00);
        ldr_req = 1'b0;
`endif

        // Randomized traffic.
        rand_mode = 1'b1;
        repeat (4000) tick();
        rand_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
